// File: rtl/weight_fetch.sv
// weight_fetch: read-side sequencer for the weight RAM buffer.
// Streams len words from base_addr, repeated passes times, to the GEMM array.
// The RAM's one-cycle read latency is hidden behind a 2-entry skid FIFO, and
// reads are only issued while a FIFO slot is guaranteed for the returning word.
module weight_fetch #(
    parameter int ADDR_SIZE  = 10,
    parameter int DATA_WIDTH = 32,
    parameter int PASS_W     = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [ADDR_SIZE-1:0]  base_addr,
    input  logic [ADDR_SIZE:0]    len,
    input  logic [PASS_W-1:0]     passes,
    output logic                  busy,
    output logic [ADDR_SIZE-1:0]  weight_addr,
    output logic                  w_addr_vld,
    input  logic [DATA_WIDTH-1:0] weight_data,
    output logic [DATA_WIDTH-1:0] wt_data,
    output logic                  wt_valid,
    input  logic                  wt_ready,
    output logic                  wt_last,
    output logic                  w_done
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

    localparam logic [ADDR_SIZE:0] LEN_ONE  = 1;
    localparam logic [PASS_W-1:0]  PASS_ONE = 1;

    state_t                 r_state, w_next;
    logic [ADDR_SIZE-1:0]   r_base;
    logic [ADDR_SIZE:0]     r_len;
    logic [PASS_W-1:0]      r_passes;
    logic [ADDR_SIZE:0]     r_idx;
    logic [PASS_W-1:0]      r_pass;
    logic                   r_inflight;
    logic                   r_tag_d;

    logic [DATA_WIDTH-1:0]  r_fifo_d [2];
    logic                   r_fifo_l [2];
    logic                   r_wp, r_rp;
    logic [1:0]             r_count;

    logic                   w_pop, w_push, w_issue, w_credit;
    logic                   w_idx_last, w_pass_last, w_accept, w_empty_job;
    logic [2:0]             w_occ;

    assign w_accept    = (r_state == S_IDLE) && start;
    assign w_empty_job = (len == '0) || (passes == '0);
    assign w_idx_last  = (r_idx == r_len - LEN_ONE);
    assign w_pass_last = (r_pass == r_passes - PASS_ONE);

    assign wt_valid = (r_count != 2'd0);
    assign w_pop    = wt_valid && wt_ready;
    assign w_push   = r_inflight;

    // Occupancy after this cycle's pop, counting the word still coming back
    // from the RAM; a new read is allowed only if it leaves a free slot.
    assign w_occ    = {1'b0, r_count} + {2'b0, r_inflight} - {2'b0, w_pop};
    assign w_credit = (w_occ < 3'd2);
    assign w_issue  = (r_state == S_FETCH) && w_credit;

    assign w_addr_vld  = w_issue;
    assign weight_addr = r_base + r_idx[ADDR_SIZE-1:0];
    assign busy        = (r_state == S_FETCH) || (r_state == S_DRAIN);
    assign w_done      = (r_state == S_DONE);

    assign wt_data = r_fifo_d[r_rp];
    assign wt_last = r_fifo_l[r_rp] && wt_valid;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic; DRAIN finishes in the cycle the final word pops
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = w_empty_job ? S_DONE : S_FETCH;
            S_FETCH: if (w_issue && w_idx_last && w_pass_last) w_next = S_DRAIN;
            S_DRAIN: if (w_occ == 3'd0) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Job parameters, index/pass counters and read-return tracking
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_base     <= '0;
            r_len      <= '0;
            r_passes   <= '0;
            r_idx      <= '0;
            r_pass     <= '0;
            r_inflight <= 1'b0;
            r_tag_d    <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            r_tag_d    <= w_issue && w_idx_last;
            if (w_accept) begin
                r_base   <= base_addr;
                r_len    <= len;
                r_passes <= passes;
                r_idx    <= '0;
                r_pass   <= '0;
            end else if (w_issue) begin
                if (w_idx_last) begin
                    r_idx  <= '0;
                    r_pass <= r_pass + PASS_ONE;
                end else begin
                    r_idx  <= r_idx + LEN_ONE;
                end
            end
        end
    end

    // Two-entry skid FIFO holding returned words and their last-of-pass tag
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_fifo_d[0] <= '0;
            r_fifo_d[1] <= '0;
            r_fifo_l[0] <= 1'b0;
            r_fifo_l[1] <= 1'b0;
            r_wp        <= 1'b0;
            r_rp        <= 1'b0;
            r_count     <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo_d[r_wp] <= weight_data;
                r_fifo_l[r_wp] <= r_tag_d;
                r_wp           <= ~r_wp;
            end
            if (w_pop) r_rp <= ~r_rp;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

endmodule

// File: tb/tb_weight_fetch.sv
// Directed bench for weight_fetch: RAM model, event log sampled on the
// falling edge, and one task per scenario with hand-computed expectations.
module tb_weight_fetch;
    localparam int AS = 10;
    localparam int DW = 32;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic [AS-1:0] base_addr = '0;
    logic [AS:0]   len = '0;
    logic [PW-1:0] passes = '0;
    logic          busy, w_addr_vld, wt_valid, wt_last, w_done;
    logic [AS-1:0] weight_addr;
    logic [DW-1:0] weight_data, wt_data;
    logic          wt_ready = 1'b1;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    weight_fetch #(.ADDR_SIZE(AS), .DATA_WIDTH(DW), .PASS_W(PW)) dut (
        .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr),
        .len(len), .passes(passes), .busy(busy), .weight_addr(weight_addr),
        .w_addr_vld(w_addr_vld), .weight_data(weight_data), .wt_data(wt_data),
        .wt_valid(wt_valid), .wt_ready(wt_ready), .wt_last(wt_last),
        .w_done(w_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: word at address a holds 32'h5A000000 + a, one-cycle read
    logic [DW-1:0] ram [0:(1<<AS)-1];
    initial for (int a = 0; a < (1 << AS); a++) ram[a] = 32'h5A00_0000 + a;
    always @(posedge clk) if (w_addr_vld) weight_data <= ram[weight_addr];

    // Event log
    logic [AS-1:0] rd_addr_q [$];
    int            rd_cyc_q  [$];
    logic [DW-1:0] out_d_q   [$];
    logic          out_l_q   [$];
    int            out_cyc_q [$];
    int            done_q    [$];
    int            n_rd, n_pop, max_out;

    always @(negedge clk) begin
        if (rstn) begin
            if (w_addr_vld) begin
                rd_addr_q.push_back(weight_addr);
                rd_cyc_q.push_back(cyc);
                n_rd++;
            end
            if (wt_valid && wt_ready) begin
                out_d_q.push_back(wt_data);
                out_l_q.push_back(wt_last);
                out_cyc_q.push_back(cyc);
                n_pop++;
            end
            if (w_done) done_q.push_back(cyc);
            if (n_rd - n_pop > max_out) max_out = n_rd - n_pop;
        end
    end

    task automatic clear_log();
        rd_addr_q.delete(); rd_cyc_q.delete();
        out_d_q.delete(); out_l_q.delete(); out_cyc_q.delete();
        done_q.delete();
        n_rd = 0; n_pop = 0; max_out = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [AS-1:0] b, input logic [AS:0] l,
                          input logic [PW-1:0] p, output int t);
        base_addr = b; len = l; passes = p; start = 1'b1;
        t = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_q.size() == 0 && n < budget) begin tick(); n++; end
        checks++;
        if (done_q.size() == 0) begin
            fails++;
            $display("FAIL done_timeout: no w_done within %0d cycles", budget);
        end
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) tick();
        checks++;
        if ({busy, w_addr_vld, wt_valid, wt_last, w_done} !== 5'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b required 00000",
                     {busy, w_addr_vld, wt_valid, wt_last, w_done});
        end
        checks++;
        if (weight_addr !== '0) begin
            fails++; $display("FAIL reset_addr: got %h required 000", weight_addr);
        end
        checks++;
        if (wt_data !== '0) begin
            fails++; $display("FAIL reset_data: got %h required 0", wt_data);
        end
        rstn = 1'b1;
        repeat (2) tick();
        checks++;
        if (busy !== 1'b0 || done_q.size() != 0) begin
            fails++; $display("FAIL reset_idle: busy %b dones %0d required 0 0", busy, done_q.size());
        end
    endtask

    task automatic test_basic();
        logic [DW-1:0] exp_d [4] = '{32'h5A000010, 32'h5A000011, 32'h5A000012, 32'h5A000013};
        int t;
        clear_log();
        wt_ready = 1'b1;
        launch(10'h010, 11'd4, 8'd1, t);
        checks++;
        if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy: got %b required 1", busy); end
        wait_done(40);
        checks++;
        if (rd_addr_q.size() != 4 || out_d_q.size() != 4) begin
            fails++; $display("FAIL basic_count: reads %0d words %0d required 4 4", rd_addr_q.size(), out_d_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rd_addr_q[i] !== 10'h010 + i || rd_cyc_q[i] != t + 1 + i) begin
                    fails++; $display("FAIL basic_read%0d: addr %h cyc %0d required %h %0d", i, rd_addr_q[i], rd_cyc_q[i] - t, 10'h010 + i, 1 + i);
                end
                checks++;
                if (out_d_q[i] !== exp_d[i] || out_l_q[i] !== (i == 3) || out_cyc_q[i] != t + 3 + i) begin
                    fails++; $display("FAIL basic_word%0d: data %h last %b cyc %0d required %h %b %0d", i, out_d_q[i], out_l_q[i], out_cyc_q[i] - t, exp_d[i], (i == 3), 3 + i);
                end
            end
        end
        checks++;
        if (done_q.size() != 1 || done_q[0] != t + 7) begin
            fails++; $display("FAIL basic_done: count %0d first %0d required 1 at T+7", done_q.size(), (done_q.size() > 0) ? done_q[0] - t : -1);
        end
    endtask

    task automatic test_multipass();
        logic [DW-1:0] exp_d [6] = '{32'h5A000020, 32'h5A000021, 32'h5A000022,
                                     32'h5A000020, 32'h5A000021, 32'h5A000022};
        logic          exp_l [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        int t;
        clear_log();
        launch(10'h020, 11'd3, 8'd2, t);
        wait_done(40);
        checks++;
        if (out_d_q.size() != 6) begin
            fails++; $display("FAIL multi_count: got %0d words required 6", out_d_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (out_d_q[i] !== exp_d[i] || out_l_q[i] !== exp_l[i]) begin
                    fails++; $display("FAIL multi_word%0d: data %h last %b required %h %b", i, out_d_q[i], out_l_q[i], exp_d[i], exp_l[i]);
                end
            end
        end
        checks++;
        if (done_q.size() != 1 || done_q[0] != t + 9) begin
            fails++; $display("FAIL multi_done: count %0d required 1 at T+9", done_q.size());
        end
    endtask

    task automatic test_wrap();
        logic [AS-1:0] exp_a [4] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        int t;
        clear_log();
        launch(10'h3FE, 11'd4, 8'd1, t);
        wait_done(40);
        checks++;
        if (rd_addr_q.size() != 4 || out_d_q.size() != 4) begin
            fails++; $display("FAIL wrap_count: reads %0d words %0d required 4 4", rd_addr_q.size(), out_d_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rd_addr_q[i] !== exp_a[i] || out_d_q[i] !== 32'h5A000000 + exp_a[i]) begin
                    fails++; $display("FAIL wrap_addr%0d: addr %h data %h required %h", i, rd_addr_q[i], out_d_q[i], exp_a[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int t, n, held;
        clear_log();
        held = -1;
        launch(10'h100, 11'd8, 8'd1, t);
        n = 0;
        while (done_q.size() == 0 && n < 300) begin
            if (n == 13) held = n_rd - n_pop;
            wt_ready = (n >= 3 && n < 13) ? 1'b0 : 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        wt_ready = 1'b1;
        checks++;
        if (done_q.size() == 0) begin fails++; $display("FAIL bp_timeout: no w_done in 300 cycles"); end
        repeat (3) tick();
        checks++;
        if (out_d_q.size() != 8) begin
            fails++; $display("FAIL bp_count: got %0d words required 8", out_d_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (out_d_q[i] !== 32'h5A000100 + i || out_l_q[i] !== (i == 7)) begin
                    fails++; $display("FAIL bp_word%0d: data %h last %b required %h %b", i, out_d_q[i], out_l_q[i], 32'h5A000100 + i, (i == 7));
                end
            end
        end
        checks++;
        if (held != 2) begin fails++; $display("FAIL bp_held: %0d buffered after stall required 2", held); end
        checks++;
        if (max_out > 2) begin fails++; $display("FAIL bp_outstanding: max %0d required <= 2", max_out); end
        checks++;
        if (done_q.size() != 1 || n_rd != 8) begin
            fails++; $display("FAIL bp_done: dones %0d reads %0d required 1 8", done_q.size(), n_rd);
        end
    endtask

    task automatic test_empty_and_ignored();
        int t, t2;
        clear_log();
        launch(10'h050, 11'd0, 8'd1, t);
        tick();
        checks++;
        if (done_q.size() != 1 || done_q[0] != t + 1 || n_rd != 0) begin
            fails++; $display("FAIL len0: dones %0d reads %0d required 1 at T+1, 0 reads", done_q.size(), n_rd);
        end
        repeat (2) tick();
        clear_log();
        launch(10'h050, 11'd4, 8'd0, t);
        tick();
        checks++;
        if (done_q.size() != 1 || done_q[0] != t + 1 || n_rd != 0) begin
            fails++; $display("FAIL passes0: dones %0d reads %0d required 1 at T+1, 0 reads", done_q.size(), n_rd);
        end
        repeat (2) tick();
        clear_log();
        launch(10'h060, 11'd4, 8'd1, t);
        launch(10'h070, 11'd2, 8'd3, t2);
        base_addr = '0; len = '0; passes = '0;
        wait_done(40);
        checks++;
        if (out_d_q.size() != 4 || done_q.size() != 1) begin
            fails++; $display("FAIL busy_start_count: words %0d dones %0d required 4 1", out_d_q.size(), done_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (out_d_q[i] !== 32'h5A000060 + i) begin
                    fails++; $display("FAIL busy_start_word%0d: got %h required %h", i, out_d_q[i], 32'h5A000060 + i);
                end
            end
        end
    endtask

    task automatic test_reset_mid_job();
        int t;
        clear_log();
        launch(10'h080, 11'd8, 8'd1, t);
        repeat (4) tick();
        #2 rstn = 1'b0;
        #1;
        checks++;
        if ({busy, w_addr_vld, wt_valid, wt_last, w_done} !== 5'b0 || weight_addr !== '0 || wt_data !== '0) begin
            fails++; $display("FAIL midreset_outputs: ctrl %b addr %h data %h required all zero",
                              {busy, w_addr_vld, wt_valid, wt_last, w_done}, weight_addr, wt_data);
        end
        repeat (2) tick();
        rstn = 1'b1;
        repeat (3) tick();
        checks++;
        if (done_q.size() != 0) begin fails++; $display("FAIL midreset_done: got %0d pulses required 0", done_q.size()); end
        clear_log();
        launch(10'h040, 11'd2, 8'd1, t);
        wait_done(40);
        checks++;
        if (out_d_q.size() != 2 || done_q.size() != 1) begin
            fails++; $display("FAIL post_reset_count: words %0d dones %0d required 2 1", out_d_q.size(), done_q.size());
        end else begin
            checks++;
            if (out_d_q[0] !== 32'h5A000040 || out_d_q[1] !== 32'h5A000041 ||
                out_l_q[0] !== 1'b0 || out_l_q[1] !== 1'b1 || done_q[0] != t + 5) begin
                fails++; $display("FAIL post_reset_job: %h/%b %h/%b done T+%0d required 5a000040/0 5a000041/1 T+5",
                                  out_d_q[0], out_l_q[0], out_d_q[1], out_l_q[1], done_q[0] - t);
            end
        end
    endtask

    initial begin
        clear_log();
        test_reset();
        test_basic();
        test_multipass();
        test_wrap();
        test_backpressure();
        test_empty_and_ignored();
        test_reset_mid_job();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
